// File: rtl/fault_injection_sequencer.sv
// Fault-injection campaign sequencer: walks one-hot fault sites, streams LFSR vectors into a
// golden/faulty CUT pair and reports a saturating per-site mismatch count over valid/ready.
module fault_injection_sequencer #(
  parameter int unsigned NUM_IN     = 3,
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned NUM_FAULTS = 8,
  parameter int unsigned CUT_LAT    = 2,
  parameter int unsigned VEC_W      = 16,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SITE_W    = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [VEC_W-1:0]      vectors_per_site,
  input  logic [15:0]           lfsr_seed,
  output logic [NUM_IN-1:0]     cut_in,
  input  logic [NUM_OUT-1:0]    golden_out,
  input  logic [NUM_OUT-1:0]    faulty_out,
  output logic [NUM_FAULTS-1:0] fault_en,
  output logic                  busy,
  output logic                  done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SITE_W-1:0]     res_site,
  output logic [CNT_W-1:0]      res_count
);

  localparam int unsigned DRAIN_W = $clog2(CUT_LAT + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StIssue, StDrain, StReport, StDone} state_e;

  state_e               state_q, state_d;
  logic [SITE_W-1:0]    site_q, site_d;
  logic [VEC_W-1:0]     n_q, n_d;
  logic [VEC_W-1:0]     idx_q, idx_d;
  logic [15:0]          seed_q, seed_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CUT_LAT-1:0]   pipe_q, pipe_d;
  logic                 issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      site_q  <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      seed_q  <= '0;
      lfsr_q  <= '0;
      drain_q <= '0;
      cnt_q   <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      site_q  <= site_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      pipe_q  <= pipe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    site_d  = site_q;
    n_d     = n_q;
    idx_d   = idx_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;

    // The delay-line head marks a cycle whose CUT outputs belong to an issued vector.
    if (pipe_q[CUT_LAT-1] && (golden_out != faulty_out) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        site_d = '0;
        if (start) begin
          n_d     = (vectors_per_site == '0) ? VEC_W'(1) : vectors_per_site;
          seed_d  = (lfsr_seed == 16'h0000) ? 16'h0001 : lfsr_seed;
          state_d = StSetup;
        end
      end
      StSetup: begin
        lfsr_d  = seed_q;
        cnt_d   = '0;
        idx_d   = '0;
        drain_d = '0;
        state_d = StIssue;
      end
      StIssue: begin
        issue  = 1'b1;
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        idx_d  = idx_q + VEC_W'(1);
        if (idx_q == n_q - VEC_W'(1)) state_d = StDrain;
      end
      StDrain: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_W'(CUT_LAT - 1)) state_d = StReport;
      end
      StReport: begin
        if (res_ready) begin
          if (site_q == SITE_W'(NUM_FAULTS - 1)) begin
            state_d = StDone;
          end else begin
            site_d  = site_q + SITE_W'(1);
            state_d = StSetup;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    pipe_d    = '0;
    pipe_d[0] = issue;
    for (int i = 1; i < CUT_LAT; i++) pipe_d[i] = pipe_q[i-1];

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      pipe_d  = '0;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    res_valid = (state_q == StReport);
    res_site  = site_q;
    res_count = cnt_q;
    cut_in    = (state_q == StIssue) ? lfsr_q[NUM_IN-1:0] : '0;
    fault_en  = '0;
    if (state_q == StSetup || state_q == StIssue || state_q == StDrain) begin
      fault_en = NUM_FAULTS'(1) << site_q;
    end
  end

endmodule
